// File: rtl/wave_generator.sv
// Programmable waveform source: triangle, saw up/down and square between
// run-time limits, with step size, prescaler, enable and a period-start pulse.
module wave_generator #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] wave,
  output logic             dir,
  output logic             wrap
);

  localparam logic [1:0] MODE_TRI   = 2'b00;
  localparam logic [1:0] MODE_SAWUP = 2'b01;
  localparam logic [1:0] MODE_SAWDN = 2'b10;
  localparam logic [1:0] MODE_SQR   = 2'b11;

  localparam logic [WIDTH-1:0] STEP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_r;
  logic             tick_s;
  logic [WIDTH-1:0] step_eff_s;
  logic [WIDTH:0]   wave_ext_s;
  logic [WIDTH:0]   hi_ext_s;
  logic [WIDTH:0]   up_sum_s;
  logic [WIDTH:0]   dn_diff_s;
  logic [WIDTH:0]   lo_plus_s;
  logic [WIDTH-1:0] wave_nx_s;
  logic             dir_nx_s;
  logic             wrap_nx_s;

  // All limit arithmetic is one bit wider so wave can never wrap modulo 2^WIDTH.
  assign tick_s     = en && (cnt_r >= div);
  assign step_eff_s = (step == {WIDTH{1'b0}}) ? STEP_ONE : step;
  assign wave_ext_s = {1'b0, wave};
  assign hi_ext_s   = {1'b0, hi};
  assign up_sum_s   = wave_ext_s + {1'b0, step_eff_s};
  assign dn_diff_s  = wave_ext_s - {1'b0, step_eff_s};
  assign lo_plus_s  = {1'b0, lo} + {1'b0, step_eff_s};

  // Prescaler: counts enabled cycles, restarts on every tick, freezes when disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (en) begin
      if (cnt_r >= div) begin
        cnt_r <= {DIV_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Next-sample decision: invalid limits, then clamp, then the per-mode rule.
  always_comb begin
    wave_nx_s = wave;
    dir_nx_s  = dir;
    wrap_nx_s = 1'b0;
    if (!tick_s) begin
      wave_nx_s = wave;
    end else if (lo >= hi) begin
      wave_nx_s = lo;
      dir_nx_s  = 1'b0;
    end else if (wave > hi) begin
      wave_nx_s = hi;
      dir_nx_s  = 1'b1;
    end else if (wave < lo) begin
      wave_nx_s = lo;
      dir_nx_s  = 1'b0;
    end else begin
      case (mode)
        MODE_TRI: begin
          if (!dir) begin
            if (up_sum_s >= hi_ext_s) begin
              wave_nx_s = hi;
              dir_nx_s  = 1'b1;
            end else begin
              wave_nx_s = up_sum_s[WIDTH-1:0];
            end
          end else begin
            // wave <= lo+step covers both undershoot and landing exactly on lo.
            if (wave_ext_s <= lo_plus_s) begin
              wave_nx_s = lo;
              dir_nx_s  = 1'b0;
              wrap_nx_s = 1'b1;
            end else begin
              wave_nx_s = dn_diff_s[WIDTH-1:0];
            end
          end
        end
        MODE_SAWUP: begin
          dir_nx_s = 1'b0;
          if (up_sum_s > hi_ext_s) begin
            wave_nx_s = lo;
            wrap_nx_s = 1'b1;
          end else begin
            wave_nx_s = up_sum_s[WIDTH-1:0];
          end
        end
        MODE_SAWDN: begin
          dir_nx_s = 1'b1;
          if (wave_ext_s < lo_plus_s) begin
            wave_nx_s = hi;
            wrap_nx_s = 1'b1;
          end else begin
            wave_nx_s = dn_diff_s[WIDTH-1:0];
          end
        end
        MODE_SQR: begin
          if (!dir) begin
            wave_nx_s = hi;
            dir_nx_s  = 1'b1;
          end else begin
            wave_nx_s = lo;
            dir_nx_s  = 1'b0;
            wrap_nx_s = 1'b1;
          end
        end
        default: begin
          wave_nx_s = wave;
          dir_nx_s  = dir;
          wrap_nx_s = 1'b0;
        end
      endcase
    end
  end

  // Output registers; wave, dir and wrap always update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wave <= {WIDTH{1'b0}};
      dir  <= 1'b0;
      wrap <= 1'b0;
    end else begin
      wave <= wave_nx_s;
      dir  <= dir_nx_s;
      wrap <= wrap_nx_s;
    end
  end

endmodule

// File: tb/tb_wave_generator.sv
// Directed self-checking bench for wave_generator (WIDTH=5, DIV_W=8).
module tb_wave_generator;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [4:0] step;
  logic [4:0] lo;
  logic [4:0] hi;
  logic [7:0] div;
  logic [4:0] wave;
  logic       dir;
  logic       wrap;

  int tests = 0;
  int fails = 0;

  int tri3 [0:22] = '{3, 6, 9, 12, 15, 18, 21, 24, 27, 30, 31, 28, 25, 22, 19, 16, 13, 10, 7, 4, 1, 0, 3};
  int sawu [0:5]  = '{0, 4, 9, 14, 19, 4};
  int sawd [0:5]  = '{4, 20, 15, 10, 5, 20};

  wave_generator #(.WIDTH(5), .DIV_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .step (step),
    .lo   (lo),
    .hi   (hi),
    .div  (div),
    .wave (wave),
    .dir  (dir),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] w, input logic d, input logic r);
    tests++;
    assert ({wave, dir, wrap} === {w, d, r}) else begin
      fails++;
      $error("FAIL %s: got wave=%0d dir=%0b wrap=%0b, expected wave=%0d dir=%0b wrap=%0b",
             tag, wave, dir, wrap, w, d, r);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [4:0] w, input logic d, input logic r);
    edge1();
    chk(tag, w, d, r);
  endtask

  task automatic hold(input int n, input string tag, input logic [4:0] w, input logic d);
    for (int i = 0; i < n; i++) begin
      edge1();
      chk(tag, w, d, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b00; step = 5'd1; lo = 5'd0; hi = 5'd31; div = 8'd0;
    edge1();
    cyc("reset", 5'd0, 1'b0, 1'b0);

    // Triangle step 1: 62-cycle period
    rst = 1'b0;
    for (int k = 1; k <= 63; k++) begin
      int ew;
      ew = (k <= 31) ? k : ((k <= 62) ? 62 - k : k - 62);
      cyc("tri1", ew[4:0], (k >= 31 && k <= 61), (k == 62));
    end

    // Reset mid-ramp with en high, then triangle step 3
    rst = 1'b1; step = 5'd3;
    cyc("rst_mid", 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i <= 22; i++) begin
      cyc("tri3", tri3[i][4:0], (i >= 10 && i <= 20), (i == 21));
    end

    // Saw up, lo=4 hi=20 step=5 div=2
    rst = 1'b1; mode = 2'b01; lo = 5'd4; hi = 5'd20; step = 5'd5; div = 8'd2;
    cyc("rst_saw", 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      cyc("sawup", sawu[e / 3][4:0], 1'b0, (e == 15));
    end
    mode = 2'b10;
    for (int e = 1; e <= 15; e++) begin
      cyc("sawdn", sawd[e / 3][4:0], (e >= 3), (e % 3 == 0) && (e == 3 || e == 15));
    end

    // Square, lo=2 hi=9 div=3, with a 5-cycle enable pause
    rst = 1'b1; mode = 2'b11; lo = 5'd2; hi = 5'd9; div = 8'd3;
    cyc("rst_sq", 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    hold(3, "sq_pre", 5'd0, 1'b0);
    cyc("sq_clamp", 5'd2, 1'b0, 1'b0);
    hold(3, "sq_lo", 5'd2, 1'b0);
    cyc("sq_hi", 5'd9, 1'b1, 1'b0);
    hold(1, "sq_hold", 5'd9, 1'b1);
    en = 1'b0;
    hold(5, "sq_pause", 5'd9, 1'b1);
    en = 1'b1;
    hold(2, "sq_resume", 5'd9, 1'b1);
    cyc("sq_wrap", 5'd2, 1'b0, 1'b1);
    hold(3, "sq_lo2", 5'd2, 1'b0);
    cyc("sq_hi2", 5'd9, 1'b1, 1'b0);

    // Lower hi below the current sample, then collapse the limits
    rst = 1'b1; mode = 2'b00; lo = 5'd0; hi = 5'd31; step = 5'd1; div = 8'd0;
    edge1();
    rst = 1'b0;
    for (int i = 0; i < 24; i++) edge1();
    cyc("tri_25", 5'd25, 1'b0, 1'b0);
    hi = 5'd10;
    cyc("hi_clamp", 5'd10, 1'b1, 1'b0);
    cyc("hi_desc1", 5'd9, 1'b1, 1'b0);
    cyc("hi_desc2", 5'd8, 1'b1, 1'b0);
    lo = 5'd7; hi = 5'd7;
    cyc("inv_lim", 5'd7, 1'b0, 1'b0);
    hold(2, "inv_hold", 5'd7, 1'b0);

    // Reset mid-ramp, then shrink div below the running count
    lo = 5'd0; hi = 5'd31;
    cyc("ramp8", 5'd8, 1'b0, 1'b0);
    cyc("ramp9", 5'd9, 1'b0, 1'b0);
    rst = 1'b1; div = 8'd100;
    cyc("rst_ramp", 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    hold(50, "div100", 5'd0, 1'b0);
    div = 8'd1;
    cyc("div_drop", 5'd1, 1'b0, 1'b0);
    hold(1, "div1_gap", 5'd1, 1'b0);
    cyc("div1_t2", 5'd2, 1'b0, 1'b0);
    hold(1, "div1_gap2", 5'd2, 1'b0);
    cyc("div1_t3", 5'd3, 1'b0, 1'b0);
    step = 5'd0;
    hold(1, "step0_gap", 5'd3, 1'b0);
    cyc("step0", 5'd4, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
